// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus arbitration interface.
// Bundles the per-master request/grant vectors, the bus begin/end/error
// strobes, and the arbiter's ownership and abort outputs.
//   slave  : arbiter side (consumes requests and strobes, drives grant/owner/abort)
//   master : requester/bus side (drives requests and strobes, observes grant/owner)
interface bus_arbiter_rr_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] request;
  logic                   beginTransactionIn;
  logic                   endTransactionIn;
  logic                   busErrorIn;
  logic [NUM_MASTERS-1:0] grant;
  logic [2:0]             busOwner;
  logic                   ownerValid;
  logic                   endTransactionOut;
  logic                   timeoutError;

  modport slave (
    input  request, beginTransactionIn, endTransactionIn, busErrorIn,
    output grant, busOwner, ownerValid, endTransactionOut, timeoutError
  );

  modport master (
    output request, beginTransactionIn, endTransactionIn, busErrorIn,
    input  grant, busOwner, ownerValid, endTransactionOut, timeoutError
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus.
// Grants the bus to one of up to 8 masters, tracks the granted transaction
// from begin to end strobe, and force-ends stalled transactions with a
// watchdog so a hung master or slave cannot lock the bus.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : arbitration interface (slave side), see bus_arbiter_rr_if
module bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned BEGIN_WINDOW    = 4,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  bus_arbiter_rr_if.slave  bus
);

  localparam int unsigned NM      = NUM_MASTERS;
  localparam int unsigned BEG_W   = 4;
  localparam int unsigned WD_W    = 16;
  localparam logic [2:0]  PTR_RST = 3'(NUM_MASTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_BEGIN,
    S_BUSY,
    S_ABORT,
    S_RELEASE
  } state_e;

  state_e           state;
  logic [2:0]       last_grant;
  logic [BEG_W-1:0] beg_cnt;
  logic [WD_W-1:0]  wd_cnt;

  logic [2:0]       winner;
  logic [BEG_W-1:0] beg_next;
  logic [WD_W-1:0]  wd_next;
  logic             beg_expired;
  logic             wd_expired;

  // First requester found searching upward from the master after last_grant.
  function automatic logic [2:0] rr_pick(input logic [NM-1:0] req,
                                         input logic [2:0]    last);
    logic [2:0]       win;
    logic             found;
    logic [NM-1:0]    shifted;
    int unsigned      idx;
    win   = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= NM; k++) begin
      idx     = (32'(last) + k) % NM;
      shifted = req >> idx;
      if (!found && shifted[0]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Saturating next counts and their expiry tests; the test looks at the
  // value the counter takes on this edge, so the timeout lands exactly on
  // the terminal count.
  always_comb begin
    winner      = rr_pick(bus.request, last_grant);
    beg_next    = (beg_cnt == {BEG_W{1'b1}}) ? beg_cnt : beg_cnt + BEG_W'(1);
    wd_next     = (wd_cnt == {WD_W{1'b1}}) ? wd_cnt : wd_cnt + WD_W'(1);
    beg_expired = (beg_next >= BEG_W'(BEGIN_WINDOW));
    wd_expired  = (wd_next >= WD_W'(WATCHDOG_CYCLES - 1));
  end

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= S_IDLE;
      last_grant            <= PTR_RST;
      beg_cnt               <= '0;
      wd_cnt                <= '0;
      bus.grant             <= '0;
      bus.busOwner          <= '0;
      bus.ownerValid        <= 1'b0;
      bus.endTransactionOut <= 1'b0;
      bus.timeoutError      <= 1'b0;
    end else begin
      bus.grant             <= '0;
      bus.endTransactionOut <= 1'b0;
      bus.timeoutError      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (|bus.request) begin
            state          <= S_GRANT;
            last_grant     <= winner;
            bus.grant      <= NM'(1) << winner;
            bus.busOwner   <= winner;
            bus.ownerValid <= 1'b1;
            beg_cnt        <= '0;
          end
        end

        S_GRANT: begin
          state   <= S_WAIT_BEGIN;
          beg_cnt <= beg_next;
        end

        S_WAIT_BEGIN: begin
          beg_cnt <= beg_next;
          if (bus.beginTransactionIn) begin
            if (bus.endTransactionIn) begin
              // Single-beat transaction: begin and end together.
              state          <= S_RELEASE;
              bus.ownerValid <= 1'b0;
            end else begin
              state  <= S_BUSY;
              wd_cnt <= '0;
            end
          end else if (beg_expired) begin
            state            <= S_IDLE;
            bus.ownerValid   <= 1'b0;
            bus.timeoutError <= 1'b1;
          end
        end

        S_BUSY: begin
          wd_cnt <= wd_next;
          if (bus.endTransactionIn) begin
            // A normal end, with or without a concurrent bus error.
            state          <= S_RELEASE;
            bus.ownerValid <= 1'b0;
          end else if (wd_expired) begin
            state                 <= S_ABORT;
            bus.ownerValid        <= 1'b0;
            bus.endTransactionOut <= 1'b1;
            bus.timeoutError      <= 1'b1;
          end else if (bus.busErrorIn) begin
            // Error without end: keep waiting, watchdog still armed.
            state <= S_BUSY;
          end
        end

        S_ABORT: begin
          state <= S_RELEASE;
        end

        S_RELEASE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed vector table plus
// randomized transactions predicted by a transaction-level reference model.
module tb_bus_arbiter_rr;

  localparam int NM = 4;
  localparam int BW = 4;
  localparam int WD = 16;

  typedef enum int {K_NORMAL, K_SINGLE, K_NOBEGIN, K_ERROR, K_HANG} kind_e;

  typedef struct {
    logic       rst;
    logic [3:0] mask;
    kind_e      kind;
    int         dly;
    int         len;
    int         exp_owner;
  } vec_t;

  logic clock;
  logic reset;

  int checks;
  int errors;
  int model_last;
  int cur_txn;

  bus_arbiter_rr_if #(.NUM_MASTERS(NM)) bus ();

  bus_arbiter_rr #(
    .NUM_MASTERS    (NM),
    .BEGIN_WINDOW   (BW),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (txn %0d): got %0h expected %0h at t=%0t", name, cur_txn, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input int owner,
                            input logic ov, input logic eto, input logic to);
    chk({tag, " grant"}, 32'(bus.grant), 32'(g));
    chk({tag, " ownerValid"}, 32'(bus.ownerValid), 32'(ov));
    chk({tag, " endTransactionOut"}, 32'(bus.endTransactionOut), 32'(eto));
    chk({tag, " timeoutError"}, 32'(bus.timeoutError), 32'(to));
    if (ov) chk({tag, " busOwner"}, 32'(bus.busOwner), 32'(owner));
  endtask

  // Reference: first requester above the previous winner, wrapping.
  function automatic int model_pick(input logic [3:0] mask);
    int idx;
    for (int k = 1; k <= NM; k++) begin
      idx = (model_last + k) % NM;
      if (mask[idx]) return idx;
    end
    return model_last;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #1;
    tick();
    tick();
    expect_out("reset", 4'b0000, 0, 1'b0, 1'b0, 1'b0);
    chk("reset busOwner", 32'(bus.busOwner), 32'd0);
    reset = 1'b0;
    model_last = NM - 1;
  endtask

  // One whole transaction, starting and ending in an IDLE cycle.
  task automatic run_txn(input logic [3:0] mask, input kind_e kind, input int dly,
                         input int len, input int w);
    int err_at;
    bus.request = mask;
    tick();
    bus.request = '0;
    expect_out("grant", 4'(1) << w, w, 1'b1, 1'b0, 1'b0);
    // An end strobe during the grant cycle must be ignored.
    bus.endTransactionIn = (kind == K_NORMAL);

    if (kind == K_NOBEGIN) begin
      for (int i = 1; i < BW; i++) begin
        tick();
        bus.endTransactionIn = 1'b0;
        expect_out("wait_begin", 4'b0000, w, 1'b1, 1'b0, 1'b0);
      end
      tick();
      expect_out("begin_timeout", 4'b0000, w, 1'b0, 1'b0, 1'b1);
      return;
    end

    for (int i = 0; i <= dly; i++) begin
      tick();
      bus.endTransactionIn = 1'b0;
      expect_out("wait_begin", 4'b0000, w, 1'b1, 1'b0, 1'b0);
    end
    bus.beginTransactionIn = 1'b1;
    bus.endTransactionIn   = (kind == K_SINGLE);
    tick();
    bus.beginTransactionIn = 1'b0;
    bus.endTransactionIn   = 1'b0;

    if (kind == K_SINGLE) begin
      expect_out("single_release", 4'b0000, w, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out("single_idle", 4'b0000, w, 1'b0, 1'b0, 1'b0);
      return;
    end

    if (kind == K_HANG) begin
      for (int i = 1; i < WD; i++) begin
        expect_out("hang_busy", 4'b0000, w, 1'b1, 1'b0, 1'b0);
        tick();
      end
      expect_out("abort", 4'b0000, w, 1'b0, 1'b1, 1'b1);
      tick();
      expect_out("abort_release", 4'b0000, w, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out("abort_idle", 4'b0000, w, 1'b0, 1'b0, 1'b0);
      return;
    end

    err_at = (len > 5) ? len - 5 : len;
    for (int i = 1; i <= len; i++) begin
      expect_out("busy", 4'b0000, w, 1'b1, 1'b0, 1'b0);
      bus.endTransactionIn = (i == len);
      bus.busErrorIn       = (kind == K_ERROR) && (i == err_at);
      tick();
      bus.endTransactionIn = 1'b0;
      bus.busErrorIn       = 1'b0;
    end
    expect_out("release", 4'b0000, w, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("idle", 4'b0000, w, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t tbl[16];

  initial begin
    kind_e k;
    int    r;
    logic [3:0] m;
    int    w;

    checks = 0;
    errors = 0;
    cur_txn = 0;
    model_last = NM - 1;
    reset = 1'b1;
    bus.request = '0;
    bus.beginTransactionIn = 1'b0;
    bus.endTransactionIn = 1'b0;
    bus.busErrorIn = 1'b0;

    tbl[0]  = '{1'b1, 4'b0101, K_NORMAL,  0, 3,  0};
    tbl[1]  = '{1'b0, 4'b0101, K_NORMAL,  0, 3,  2};
    tbl[2]  = '{1'b0, 4'b0101, K_NORMAL,  0, 3,  0};
    tbl[3]  = '{1'b1, 4'b1111, K_NORMAL,  0, 2,  0};
    tbl[4]  = '{1'b0, 4'b1111, K_NORMAL,  0, 2,  1};
    tbl[5]  = '{1'b0, 4'b1111, K_NORMAL,  0, 2,  2};
    tbl[6]  = '{1'b0, 4'b1111, K_NORMAL,  0, 2,  3};
    tbl[7]  = '{1'b0, 4'b1111, K_NORMAL,  0, 2,  0};
    tbl[8]  = '{1'b0, 4'b0010, K_NOBEGIN, 0, 0,  1};
    tbl[9]  = '{1'b0, 4'b0110, K_NORMAL,  0, 1,  2};
    tbl[10] = '{1'b0, 4'b1001, K_HANG,    0, 0,  3};
    tbl[11] = '{1'b0, 4'b0001, K_NORMAL,  1, 2,  0};
    tbl[12] = '{1'b0, 4'b0010, K_ERROR,   0, 7,  1};
    tbl[13] = '{1'b0, 4'b1100, K_SINGLE,  0, 0,  2};
    tbl[14] = '{1'b0, 4'b1100, K_NORMAL,  2, 15, 3};
    tbl[15] = '{1'b0, 4'b0001, K_SINGLE,  0, 0,  0};

    do_reset();

    for (int i = 0; i < 16; i++) begin
      cur_txn = i;
      if (tbl[i].rst) do_reset();
      run_txn(tbl[i].mask, tbl[i].kind, tbl[i].dly, tbl[i].len, tbl[i].exp_owner);
      model_last = tbl[i].exp_owner;
    end

    // Strobes with no request in IDLE are ignored.
    cur_txn = 100;
    bus.beginTransactionIn = 1'b1;
    bus.endTransactionIn   = 1'b1;
    bus.busErrorIn         = 1'b1;
    tick();
    bus.beginTransactionIn = 1'b0;
    bus.endTransactionIn   = 1'b0;
    bus.busErrorIn         = 1'b0;
    expect_out("idle_strobes", 4'b0000, 0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("idle_quiet", 4'b0000, 0, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-BUSY clears outputs without waiting for an edge.
    cur_txn = 101;
    w = model_pick(4'b0100);
    model_last = w;
    bus.request = 4'b0100;
    tick();
    bus.request = '0;
    expect_out("pre_reset_grant", 4'(1) << w, w, 1'b1, 1'b0, 1'b0);
    tick();
    bus.beginTransactionIn = 1'b1;
    tick();
    bus.beginTransactionIn = 1'b0;
    tick();
    expect_out("pre_reset_busy", 4'b0000, w, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset ownerValid", 32'(bus.ownerValid), 32'd0);
    chk("async_reset busOwner", 32'(bus.busOwner), 32'd0);
    chk("async_reset grant", 32'(bus.grant), 32'd0);
    tick();
    reset = 1'b0;
    model_last = NM - 1;
    run_txn(4'b1111, K_NORMAL, 0, 2, 0);
    model_last = 0;

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      cur_txn = 200 + t;
      m = 4'($urandom_range(1, 15));
      r = $urandom_range(0, 99);
      if (r < 55)      k = K_NORMAL;
      else if (r < 70) k = K_SINGLE;
      else if (r < 82) k = K_NOBEGIN;
      else if (r < 94) k = K_ERROR;
      else             k = K_HANG;
      w = model_pick(m);
      model_last = w;
      run_txn(m, k, $urandom_range(0, BW - 2), $urandom_range(1, WD - 1), w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
